// File: rtl/sprite_scan_chain.sv
// sprite_scan_chain: per-line OAM scan keeping up to SLOTS visible sprites, then X-match queries with valid/ready hits.
// Optional SPRITE_OVF_EN adds ovf/dropped overflow reporting.
module sprite_scan_chain #(
  parameter int SLOTS = 10,
  parameter int OAM_ENTRIES = 40,
  parameter int AW = 7
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          scan_start,
  input  logic [7:0]    ly,
  input  logic          cfg_tall,
  output logic [AW-1:0] oam_addr,
  input  logic [15:0]   oam_d,
  output logic          scan_busy,
  output logic          scan_done,
  input  logic          q_en,
  input  logic [7:0]    q_x,
  output logic          hit_valid,
  output logic [14:0]   hit_data,
  input  logic          hit_ready,
  output logic [4:0]    count
`ifdef SPRITE_OVF_EN
  ,
  output logic          ovf,
  output logic [5:0]    dropped
`endif
);
  localparam logic [1:0] IDLE = 2'd0, SCAN = 2'd1, READY = 2'd2;
  localparam logic [AW-1:0] LAST = AW'(2 * OAM_ENTRIES - 1);
  logic [1:0] state;
  logic [7:0] ly_r, ey, ex, dy;
  logic tall_r, vis, take, keep;
  logic [3:0] rowc, sel;
  logic [14:0] ent;
  logic [SLOTS-1:0] cons;
  logic [7:0] slot_x [SLOTS];
  logic [14:0] slot_d [SLOTS];
  always_comb begin
    scan_busy = state == SCAN;
    scan_done = scan_busy & (oam_addr == LAST) & ~scan_start;
    dy = ly_r - (ey - 8'd16);
    vis = dy < (tall_r ? 8'd16 : 8'd8);
    rowc = oam_d[14] ? ~dy[3:0] : dy[3:0];
    ent = {rowc[2:0], tall_r ? {oam_d[7:1], rowc[3]} : oam_d[7:0], oam_d[15:12]};
    take = scan_busy & oam_addr[0] & vis & ~scan_start;
    keep = take & (count < 5'(SLOTS));
  end
  // Walk downward so the lowest-index match wins.
  always_comb begin
    hit_valid = 1'b0;
    hit_data = '0;
    sel = '0;
    for (int i = SLOTS - 1; i >= 0; i--)
      if (state == READY && q_en && 5'(i) < count && !cons[i] && slot_x[i] == q_x) begin
        hit_valid = 1'b1;
        hit_data = slot_d[i];
        sel = 4'(i);
      end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      oam_addr <= '0;
      count <= '0;
      cons <= '0;
      ly_r <= '0;
      tall_r <= 1'b0;
      ey <= '0;
      ex <= '0;
    end else if (scan_start) begin
      state <= SCAN;
      oam_addr <= '0;
      count <= '0;
      cons <= '0;
      ly_r <= ly;
      tall_r <= cfg_tall;
    end else if (scan_busy) begin
      oam_addr <= scan_done ? '0 : oam_addr + 1'b1;
      if (scan_done) state <= READY;
      if (!oam_addr[0]) {ex, ey} <= oam_d;
      if (keep) count <= count + 5'd1;
    end else if (hit_valid && hit_ready)
      cons[sel] <= 1'b1;
  always_ff @(posedge clk)
    if (keep) begin
      slot_x[count[3:0]] <= ex;
      slot_d[count[3:0]] <= ent;
    end
`ifdef SPRITE_OVF_EN
  always_ff @(posedge clk or posedge rst)
    if (rst) dropped <= '0;
    else if (scan_start) dropped <= '0;
    else if (take && !keep && dropped != 6'd63) dropped <= dropped + 6'd1;
  assign ovf = |dropped;
`endif
endmodule
